// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the Uart8 receiver and the uart_tx8
// transmitter.
//
// Contents:
//   uartState_t   - FSM state encoding (IDLE, START, DATA, STOP)
//   DATA_BITS     - data bits per frame (8N1)
//   STOP_BITS     - stop bits per frame (8N1)
//   LINE_IDLE     - idle / stop level of the serial line
//   LINE_START    - start-bit level of the serial line
//   bitPeriod()   - clocks per bit, using integer division
//   counterWidth()- width of a counter that must reach period-1, at least 1
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uartState_t;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Any remainder of the division is dropped, so the real baud rate is
    // slightly higher than requested when the clock is not an exact multiple.
    function automatic int bitPeriod(input int clockRate, input int baudRate);
        return clockRate / baudRate;
    endfunction

    // $clog2(1) is 0, which would make a zero-width vector; clamp to 1 bit.
    function automatic int counterWidth(input int period);
        int w;
        w = $clog2(period);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer for the UART transmitter.
//
// Parameters:
//   CLOCK_RATE - input clock frequency in Hz
//   BAUD_RATE  - line bit rate in bit/s
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset (counter to 0)
//   clear - restarts the bit period; the counter is 0 after the edge
//   tick  - high during the last clock of each bit period, so a consumer
//           sampling it on the rising edge acts exactly N clocks after clear
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int BIT_PERIOD = bitPeriod(CLOCK_RATE, BAUD_RATE);
    localparam int CNT_W      = counterWidth(BIT_PERIOD);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIT_PERIOD - 1);

    logic [CNT_W-1:0] count;

    // Free-running modulo-N counter; clear re-aligns it to the frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx8.sv
// 8N1 UART transmitter.
//
// Parameters:
//   CLOCK_RATE - input clock frequency in Hz
//   BAUD_RATE  - line bit rate in bit/s
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous, active-high reset
//   txEn    - transmitter enable; gates acceptance of new frames only
//   txStart - request to send txIn (sampled in IDLE)
//   txIn    - byte to send
//   txOut   - serial line, registered, idle high
//   txBusy  - high while a frame is on the line
//   txDone  - single-cycle pulse in the first IDLE cycle after a frame
//
// Frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts
// CLOCK_RATE / BAUD_RATE clocks. A request in the txDone cycle is accepted,
// so back-to-back frames repeat every 10N+1 clocks.
module uart_tx8
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] txIn,
    output logic       txOut,
    output logic       txBusy,
    output logic       txDone
);

    localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);

    uartState_t  state;
    logic [7:0]  shiftReg;
    logic [2:0]  bitIdx;
    logic        acceptFrame;
    logic        bitTick;

    // A request is only looked at in IDLE; anything arriving mid-frame is
    // dropped rather than queued.
    assign acceptFrame = (state == IDLE) && txEn && txStart;

    // The acceptance edge also restarts the bit timer so the start bit is
    // exactly N clocks long regardless of where the free-running count was.
    baud_tick_gen #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE)
    ) u_tickGen (
        .clk   (clk),
        .reset (reset),
        .clear (acceptFrame),
        .tick  (bitTick)
    );

    // Transmit FSM. All outputs are registered here, so txOut changes only
    // on clock edges. The shift register is pre-shifted when each data bit
    // is put on the line, so shiftReg[0] is always the next bit to send.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            txOut    <= LINE_IDLE;
            txBusy   <= 1'b0;
            txDone   <= 1'b0;
            shiftReg <= '0;
            bitIdx   <= '0;
        end else begin
            txDone <= 1'b0;
            case (state)
                IDLE: begin
                    txOut  <= LINE_IDLE;
                    txBusy <= 1'b0;
                    if (acceptFrame) begin
                        shiftReg <= txIn;
                        bitIdx   <= '0;
                        txOut    <= LINE_START;
                        txBusy   <= 1'b1;
                        state    <= START;
                    end
                end

                START: begin
                    if (bitTick) begin
                        txOut    <= shiftReg[0];
                        shiftReg <= shiftReg >> 1;
                        bitIdx   <= '0;
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (bitTick) begin
                        if (bitIdx == LAST_DATA_IDX) begin
                            txOut <= LINE_IDLE;
                            state <= STOP;
                        end else begin
                            txOut    <= shiftReg[0];
                            shiftReg <= shiftReg >> 1;
                            bitIdx   <= bitIdx + 3'd1;
                        end
                    end
                end

                STOP: begin
                    // txDone lands in the first IDLE cycle, which is also the
                    // cycle in which a follow-on request can be accepted.
                    if (bitTick) begin
                        txOut  <= LINE_IDLE;
                        txBusy <= 1'b0;
                        txDone <= 1'b1;
                        state  <= IDLE;
                    end
                end

                default: begin
                    txOut  <= LINE_IDLE;
                    txBusy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx8.sv
// Self-checking testbench for uart_tx8.
// Uses a short bit period (1050 Hz / 100 baud -> N = 10, exercising the
// integer division) so many frames fit in a short run. Expected line levels
// come from the frame rule: cycle c after acceptance carries frame bit
// (c-1)/N, where bit 0 is start, bits 1..8 are data LSB first, bit 9 is stop.
module tb_uart_tx8;

    localparam int CLK_RATE = 1050;
    localparam int BAUD     = 100;
    localparam int N        = CLK_RATE / BAUD;

    logic       clk;
    logic       reset;
    logic       txEn;
    logic       txStart;
    logic [7:0] txIn;
    logic       txOut;
    logic       txBusy;
    logic       txDone;

    int testsRun;
    int testsFailed;

    uart_tx8 #(
        .CLOCK_RATE (CLK_RATE),
        .BAUD_RATE  (BAUD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .txEn    (txEn),
        .txStart (txStart),
        .txIn    (txIn),
        .txOut   (txOut),
        .txBusy  (txBusy),
        .txDone  (txDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: line level c cycles after the acceptance edge (1..10N).
    function automatic logic expectedLine(input logic [7:0] d, input int c);
        int slot;
        slot = (c - 1) / N;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return d[slot-1];
    endfunction

    // Caller has raised txStart at a negedge. Waits for the acceptance edge
    // and checks every cycle of the frame, the txDone cycle and (unless
    // chaining) the idle cycle after it. Optional side-stimulus: a spurious
    // request at cycle glitchAt, txEn drop at cycle enDropAt, and a chained
    // request raised in the txDone cycle.
    task automatic checkFrame(input logic [7:0] expByte, input int glitchAt,
                              input logic [7:0] glitchByte, input int enDropAt,
                              input bit chain, input logic [7:0] chainByte,
                              input string name);
        int errs;
        int firstBad;
        logic expOut;
        errs = 0;
        firstBad = -1;
        @(posedge clk);
        for (int c = 1; c <= 10 * N; c++) begin
            @(negedge clk);
            if (c == 1) txStart = 1'b0;
            expOut = expectedLine(expByte, c);
            if (txOut !== expOut || txBusy !== 1'b1 || txDone !== 1'b0) begin
                errs++;
                if (firstBad < 0) firstBad = c;
            end
            if (c == glitchAt) begin
                txStart = 1'b1;
                txIn    = glitchByte;
            end
            if (c == glitchAt + 1) begin
                txStart = 1'b0;
                txIn    = 8'($urandom);
            end
            if (c == enDropAt) txEn = 1'b0;
        end
        testsRun++;
        if (errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL %s waveform: %0d bad cycles (first at T+%0d), required 0, byte %h",
                     name, errs, firstBad, expByte);
        end
        @(negedge clk);
        testsRun++;
        if (txDone !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s txDone at T+10N+1: got %b, required 1", name, txDone);
        end
        testsRun++;
        if (txBusy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s txBusy at T+10N+1: got %b, required 0", name, txBusy);
        end
        testsRun++;
        if (txOut !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s txOut at T+10N+1: got %b, required 1", name, txOut);
        end
        if (chain) begin
            txStart = 1'b1;
            txIn    = chainByte;
        end else begin
            @(negedge clk);
            testsRun++;
            if (txDone !== 1'b0 || txBusy !== 1'b0 || txOut !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL %s idle after done: out/busy/done=%b%b%b, required 100",
                         name, txOut, txBusy, txDone);
            end
        end
    endtask

    task automatic test_reset();
        int errs;
        reset   = 1'b1;
        txEn    = 1'b0;
        txStart = 1'b0;
        txIn    = 8'h00;
        #1;
        testsRun++;
        if (txOut !== 1'b1 || txBusy !== 1'b0 || txDone !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async reset: out/busy/done=%b%b%b, required 100",
                     txOut, txBusy, txDone);
        end
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (txOut !== 1'b1 || txBusy !== 1'b0 || txDone !== 1'b0) errs++;
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (txOut !== 1'b1 || txBusy !== 1'b0 || txDone !== 1'b0) errs++;
        end
        testsRun++;
        if (errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL reset/idle hold: %0d bad cycles, required 0", errs);
        end
    endtask

    task automatic test_fixed_frame();
        txEn    = 1'b1;
        txIn    = 8'b01010110;
        txStart = 1'b1;
        checkFrame(8'h56, -1, 8'h00, -1, 1'b0, 8'h00, "frame56");
    endtask

    task automatic test_random_frames();
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            txEn    = 1'b1;
            txIn    = b;
            txStart = 1'b1;
            checkFrame(b, -1, 8'h00, -1, 1'b0, 8'h00, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b3;
        b3      = 8'($urandom);
        txEn    = 1'b1;
        txIn    = 8'h56;
        txStart = 1'b1;
        checkFrame(8'h56, -1, 8'h00, -1, 1'b1, 8'hA5, "b2b56");
        checkFrame(8'hA5, -1, 8'h00, -1, 1'b1, b3, "b2bA5");
        checkFrame(b3, -1, 8'h00, -1, 1'b0, 8'h00, "b2bRand");
    endtask

    task automatic test_ignore_while_busy();
        txEn    = 1'b1;
        txIn    = 8'h56;
        txStart = 1'b1;
        checkFrame(8'h56, 3 * N, 8'hFF, -1, 1'b0, 8'h00, "ignoreBusy");
    endtask

    task automatic test_enable();
        int errs;
        logic [7:0] b;
        errs = 0;
        txEn    = 1'b0;
        txStart = 1'b1;
        txIn    = 8'($urandom);
        for (int i = 0; i < 3 * N; i++) begin
            @(negedge clk);
            if (txOut !== 1'b1 || txBusy !== 1'b0 || txDone !== 1'b0) errs++;
        end
        testsRun++;
        if (errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL txEn low blocks frame: %0d bad cycles, required 0", errs);
        end
        txStart = 1'b0;
        txEn    = 1'b1;
        @(negedge clk);
        b       = 8'($urandom);
        txIn    = b;
        txStart = 1'b1;
        checkFrame(b, -1, 8'h00, 5 * N, 1'b0, 8'h00, "enDrop");
        txEn = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int errs;
        logic [7:0] b;
        b       = 8'($urandom);
        errs    = 0;
        txEn    = 1'b1;
        txIn    = b;
        txStart = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 6 * N; c++) begin
            @(negedge clk);
            if (c == 1) txStart = 1'b0;
            if (txOut !== expectedLine(b, c) || txBusy !== 1'b1) errs++;
        end
        testsRun++;
        if (errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL pre-reset frame: %0d bad cycles, required 0", errs);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        testsRun++;
        if (txOut !== 1'b1 || txBusy !== 1'b0 || txDone !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid-frame reset: out/busy/done=%b%b%b, required 100",
                     txOut, txBusy, txDone);
        end
        errs = 0;
        txStart = 1'b1;
        txIn    = 8'hFF;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (txOut !== 1'b1 || txBusy !== 1'b0 || txDone !== 1'b0) errs++;
        end
        testsRun++;
        if (errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL held reset: %0d bad cycles, required 0", errs);
        end
        reset   = 1'b0;
        txIn    = 8'h3C;
        txStart = 1'b1;
        checkFrame(8'h3C, -1, 8'h00, -1, 1'b0, 8'h00, "after reset 3C");
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_fixed_frame();
        test_random_frames();
        test_back_to_back();
        test_ignore_while_busy();
        test_enable();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
